// File: rtl/crc16_tx_framer.sv
// ---------------------------------------------------------------------------
// crc16_tx_framer
//
// Transmit-side packet framer for the motion-board serial link. It latches a
// parallel payload word and emits the packet one byte at a time over a
// valid/ready handshake, normally into the UART TX:
//
//   0xFF, 0xFA, payload byte 0 .. payload byte N-1, CRC[15:8], CRC[7:0]
//
// The CRC is CRC-16/XMODEM (poly 0x1021, init 0x0000, MSB-first, no
// reflection, no final XOR). It is folded one whole byte per accepted byte,
// so it is ready exactly when the last payload byte leaves.
//
// Parameters:
//   PAYLOAD_SIZE        payload bytes per packet (1..32)
//   CRC_INCLUDE_HEADER  1 = 0xFF/0xFA are part of the CRC, 0 = payload only
//
// Ports:
//   iClk        system clock
//   iRst        synchronous reset, active-high, highest priority
//   iDataValid  request to send iData, only looked at while oReady=1
//   iData       payload, byte k (k=0 first) = iData[8*(PAYLOAD_SIZE-k)-1 -: 8]
//   oReady      high only in IDLE, a new payload can be accepted
//   oByte       current output byte
//   oByteValid  oByte is valid
//   iByteReady  downstream accepts oByte this cycle
//   oFinish     one-cycle pulse after the last CRC byte is accepted
//   oCrc        CRC of the most recent completed packet
// ---------------------------------------------------------------------------
module crc16_tx_framer #(
  parameter int PAYLOAD_SIZE       = 5,
  parameter bit CRC_INCLUDE_HEADER = 1'b1
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iDataValid,
  input  logic [PAYLOAD_SIZE*8-1:0] iData,
  output logic                      oReady,
  output logic [7:0]                oByte,
  output logic                      oByteValid,
  input  logic                      iByteReady,
  output logic                      oFinish,
  output logic [15:0]               oCrc
);

  localparam int PW = PAYLOAD_SIZE * 8;
  localparam int CW = $clog2(PAYLOAD_SIZE + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(PAYLOAD_SIZE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [7:0] HDR0_BYTE = 8'hFF;
  localparam logic [7:0] HDR1_BYTE = 8'hFA;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    PAYLOAD,
    CRC_HI,
    CRC_LO
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   shift_q, shift_d;
  logic [15:0]     crc_q, crc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            finish_q, finish_d;
  logic [15:0]     crc_out_q, crc_out_d;

  logic            xfer;
  logic [15:0]     crc_next;

  // One full XMODEM byte step: the eight shift/XOR iterations unroll into a
  // single combinational network, so a byte is folded every clock.
  function automatic logic [15:0] crc16_fold(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ 16'h1021;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  // The byte being folded is always the one currently on oByte, so the
  // accumulator plus the transferring byte gives the forwarded CRC used to
  // load CRC_HI in the same cycle the last payload byte leaves.
  assign xfer     = valid_q & iByteReady;
  assign crc_next = crc16_fold(crc_q, byte_q);

  // Next-state and datapath logic. Every state advances only on a transfer,
  // which keeps oByte and oByteValid frozen while downstream stalls.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    valid_d   = valid_q;
    finish_d  = 1'b0;
    crc_out_d = crc_out_q;

    case (state_q)
      IDLE: begin
        if (iDataValid) begin
          state_d = HDR0;
          shift_d = iData;
          crc_d   = 16'h0000;
          cnt_d   = '0;
          byte_d  = HDR0_BYTE;
          valid_d = 1'b1;
        end
      end

      HDR0: begin
        if (xfer) begin
          state_d = HDR1;
          byte_d  = HDR1_BYTE;
          if (CRC_INCLUDE_HEADER) begin
            crc_d = crc_next;
          end
        end
      end

      HDR1: begin
        if (xfer) begin
          state_d = PAYLOAD;
          byte_d  = shift_q[PW-1 -: 8];
          shift_d = shift_q << 8;
          if (CRC_INCLUDE_HEADER) begin
            crc_d = crc_next;
          end
        end
      end

      // cnt_q counts payload bytes already accepted; when it reaches the
      // last index the byte on the wire is the final payload byte.
      PAYLOAD: begin
        if (xfer) begin
          crc_d = crc_next;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_IDX) begin
            state_d = CRC_HI;
            byte_d  = crc_next[15:8];
          end else begin
            byte_d  = shift_q[PW-1 -: 8];
            shift_d = shift_q << 8;
          end
        end
      end

      CRC_HI: begin
        if (xfer) begin
          state_d = CRC_LO;
          byte_d  = crc_q[7:0];
        end
      end

      // Returning to IDLE here makes oReady high in the oFinish cycle, so a
      // waiting request is taken with no extra gap.
      CRC_LO: begin
        if (xfer) begin
          state_d   = IDLE;
          byte_d    = 8'h00;
          valid_d   = 1'b0;
          finish_d  = 1'b1;
          crc_out_d = crc_q;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers. Reset wins over everything and abandons
  // any packet in flight without a finish pulse.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      crc_q     <= 16'h0000;
      cnt_q     <= '0;
      byte_q    <= 8'h00;
      valid_q   <= 1'b0;
      finish_q  <= 1'b0;
      crc_out_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      finish_q  <= finish_d;
      crc_out_q <= crc_out_d;
    end
  end

  assign oReady     = (state_q == IDLE);
  assign oByte      = byte_q;
  assign oByteValid = valid_q;
  assign oFinish    = finish_q;
  assign oCrc       = crc_out_q;

endmodule

// File: tb/tb_crc16_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_crc16_tx_framer
//
// Self-checking bench for crc16_tx_framer. A default instance (5-byte
// payload, header in CRC) gets directed and randomized packets with optional
// random backpressure; a second instance (9-byte payload, header excluded)
// is driven with the "123456789" check string. Expected bytes and CRCs come
// from a reference model that divides the augmented message bit stream by
// the generator polynomial.
// ---------------------------------------------------------------------------
module tb_crc16_tx_framer;

  localparam int P  = 5;
  localparam int PW = P * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          data_valid;
  logic [PW-1:0] data;
  logic          ready;
  logic [7:0]    obyte;
  logic          byte_valid;
  logic          byte_ready;
  logic          finish;
  logic [15:0]   crc;

  logic          data_valid9;
  logic [71:0]   data9;
  logic          ready9;
  logic [7:0]    byte9;
  logic          byte_valid9;
  logic          byte_ready9;
  logic          finish9;
  logic [15:0]   crc9;

  int            n_asserts = 0;
  int            n_fails   = 0;

  logic [7:0]    msgq[$];
  logic [7:0]    expq[$];
  logic [7:0]    rxq[$];
  logic [7:0]    exp_a[$];
  logic [15:0]   exp_crc;
  logic [15:0]   last_crc;

  always #10 clk = ~clk;

  crc16_tx_framer #(
    .PAYLOAD_SIZE(P),
    .CRC_INCLUDE_HEADER(1'b1)
  ) dut (
    .iClk(clk),
    .iRst(rst),
    .iDataValid(data_valid),
    .iData(data),
    .oReady(ready),
    .oByte(obyte),
    .oByteValid(byte_valid),
    .iByteReady(byte_ready),
    .oFinish(finish),
    .oCrc(crc)
  );

  crc16_tx_framer #(
    .PAYLOAD_SIZE(9),
    .CRC_INCLUDE_HEADER(1'b0)
  ) dut9 (
    .iClk(clk),
    .iRst(rst),
    .iDataValid(data_valid9),
    .iData(data9),
    .oReady(ready9),
    .oByte(byte9),
    .oByteValid(byte_valid9),
    .iByteReady(byte_ready9),
    .oFinish(finish9),
    .oCrc(crc9)
  );

  // Hard stop in case something upstream of the bounded loops wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // CRC-16/XMODEM as polynomial division: remainder of msg(x)*x^16 mod
  // 0x11021, computed bit by bit over the message followed by 16 zeros.
  function automatic logic [15:0] model_crc();
    logic [16:0] rem;
    int          nbits;
    logic        b;
    rem   = 17'h0;
    nbits = msgq.size() * 8;
    for (int i = 0; i < nbits + 16; i++) begin
      if (i < nbits) b = msgq[i / 8][7 - (i % 8)];
      else           b = 1'b0;
      rem = {rem[15:0], b};
      if (rem[16]) rem = rem ^ 17'h11021;
    end
    return rem[15:0];
  endfunction

  // Expected on-wire packet and CRC for a payload.
  task automatic build_expected(input logic [255:0] pay, input int psize,
                                input bit inc_hdr);
    logic [7:0] b;
    msgq.delete();
    expq.delete();
    expq.push_back(8'hFF);
    expq.push_back(8'hFA);
    if (inc_hdr) begin
      msgq.push_back(8'hFF);
      msgq.push_back(8'hFA);
    end
    for (int k = 0; k < psize; k++) begin
      b = pay[8*(psize-k)-1 -: 8];
      expq.push_back(b);
      msgq.push_back(b);
    end
    exp_crc = model_crc();
    expq.push_back(exp_crc[15:8]);
    expq.push_back(exp_crc[7:0]);
  endtask

  // Issues one request from IDLE, then scrambles iData to show the packet
  // was latched.
  task automatic applyStimulus(input logic [PW-1:0] pay);
    checkOutput("ready_before_req", ready, 1'b1);
    data       = pay;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    data       = PW'({$urandom(), $urandom()});
  endtask

  // Collects bytes from the default instance. Checks stall stability and
  // that no finish appears while bytes are still flowing. pulse_at injects a
  // request with alt while that byte index is presented; reset_at asserts
  // reset while that byte index is presented and stops there.
  task automatic receive_packet(input int n_bytes, input bit bp,
                                input int pulse_at, input int reset_at,
                                input logic [PW-1:0] alt, output int cycles);
    int         got;
    int         guard;
    bit         stalled;
    bit         pulsed;
    logic [7:0] held;
    got = 0; guard = 0; stalled = 0; pulsed = 0; held = 8'h00; cycles = 0;
    rxq.delete();
    while (got < n_bytes && guard < 400) begin
      if (stalled) begin
        checkOutput("stall_valid", byte_valid, 1'b1);
        checkOutput("stall_byte", obyte, held);
      end
      if (byte_valid) checkOutput("no_early_finish", finish, 1'b0);
      byte_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (got == reset_at && byte_valid) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        byte_ready = 1'b0;
        return;
      end
      if (got == pulse_at && !pulsed) begin
        data_valid = 1'b1;
        data       = alt;
        pulsed     = 1'b1;
      end
      if (byte_valid && byte_ready) begin
        rxq.push_back(obyte);
        got++;
        stalled = 1'b0;
      end else if (byte_valid) begin
        stalled = 1'b1;
        held    = obyte;
      end
      @(posedge clk); #1;
      data_valid = 1'b0;
      cycles++;
      guard++;
    end
    if (got < n_bytes) checkOutput("byte_timeout", got, n_bytes);
    byte_ready = 1'b0;
  endtask

  // Compares the received stream with expq and checks the completion cycle.
  task automatic check_packet(input string tag);
    checkOutput({tag, "_len"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      if (i < rxq.size()) checkOutput($sformatf("%s_byte%0d", tag, i), rxq[i], expq[i]);
    end
    checkOutput({tag, "_finish"}, finish, 1'b1);
    checkOutput({tag, "_valid_low"}, byte_valid, 1'b0);
    checkOutput({tag, "_ready"}, ready, 1'b1);
    checkOutput({tag, "_crc"}, crc, exp_crc);
    last_crc = exp_crc;
    @(posedge clk); #1;
    checkOutput({tag, "_finish_clear"}, finish, 1'b0);
  endtask

  initial begin
    logic [7:0]    kv [13];
    logic [PW-1:0] pay;
    logic [PW-1:0] pay_b;
    logic [63:0]   rnd;
    logic [15:0]   zc;
    int            cyc;

    kv = '{8'hFF, 8'hFA, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
           8'h37, 8'h38, 8'h39, 8'h31, 8'hC3};

    rst = 1'b1; data_valid = 1'b0; data = '0; byte_ready = 1'b0;
    data_valid9 = 1'b0; data9 = '0; byte_ready9 = 1'b1;
    last_crc = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", ready, 1'b1);
    checkOutput("rst_byte", obyte, 8'h00);
    checkOutput("rst_valid", byte_valid, 1'b0);
    checkOutput("rst_finish", finish, 1'b0);
    checkOutput("rst_crc", crc, 16'h0000);
    checkOutput("rst_ready9", ready9, 1'b1);
    checkOutput("rst_crc9", crc9, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] known vector 123456789, payload-only CRC");
    data9       = 72'h313233343536373839;
    data_valid9 = 1'b1;
    @(posedge clk); #1;
    data_valid9 = 1'b0;
    data9       = '0;
    for (int i = 0; i < 13; i++) begin
      checkOutput($sformatf("kv_valid%0d", i), byte_valid9, 1'b1);
      checkOutput($sformatf("kv_byte%0d", i), byte9, kv[i]);
      checkOutput($sformatf("kv_nofin%0d", i), finish9, 1'b0);
      @(posedge clk); #1;
    end
    checkOutput("kv_finish", finish9, 1'b1);
    checkOutput("kv_valid_low", byte_valid9, 1'b0);
    checkOutput("kv_crc", crc9, 16'h31C3);
    build_expected(256'h313233343536373839, 9, 1'b0);
    checkOutput("kv_model_crc", crc9, exp_crc);

    $display("[TB] fixed payload, no backpressure");
    pay = 40'h8080800000;
    build_expected(pay, P, 1'b1);
    exp_a = expq;
    applyStimulus(pay);
    receive_packet(P + 4, 1'b0, -1, -1, '0, cyc);
    checkOutput("nobp_consecutive", cyc, P + 4);
    check_packet("nobp");

    $display("[TB] fixed payload, random backpressure");
    applyStimulus(pay);
    receive_packet(P + 4, 1'b1, -1, -1, '0, cyc);
    check_packet("bp");

    $display("[TB] random payloads with backpressure");
    for (int n = 0; n < 4; n++) begin
      rnd = {$urandom(), $urandom()};
      pay = rnd[PW-1:0];
      build_expected(pay, P, 1'b1);
      applyStimulus(pay);
      receive_packet(P + 4, 1'b1, -1, -1, '0, cyc);
      check_packet($sformatf("rand%0d", n));
    end

    $display("[TB] request during payload is ignored");
    pay   = 40'hA1B2C3D4E5;
    pay_b = 40'h0102030405;
    build_expected(pay, P, 1'b1);
    applyStimulus(pay);
    receive_packet(P + 4, 1'b1, 5, -1, pay_b, cyc);
    check_packet("ign");
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("ign_quiet%0d", i), byte_valid, 1'b0);
      @(posedge clk); #1;
    end

    // Packet whose last two payload bytes are the CRC of everything before
    // them, so its own CRC is zero and oCrc reads 0 before and after reset.
    msgq.delete();
    msgq.push_back(8'hFF); msgq.push_back(8'hFA);
    msgq.push_back(8'h12); msgq.push_back(8'h34); msgq.push_back(8'h56);
    zc  = model_crc();
    pay = {24'h123456, zc};
    build_expected(pay, P, 1'b1);
    checkOutput("zero_crc_model", exp_crc, 16'h0000);
    applyStimulus(pay);
    receive_packet(P + 4, 1'b0, -1, -1, '0, cyc);
    check_packet("zcrc");

    $display("[TB] reset while third payload byte is presented");
    pay = 40'h5A5A5A5A5A;
    applyStimulus(pay);
    receive_packet(P + 4, 1'b1, -1, 4, '0, cyc);
    checkOutput("rst_mid_valid", byte_valid, 1'b0);
    checkOutput("rst_mid_ready", ready, 1'b1);
    checkOutput("rst_mid_finish", finish, 1'b0);
    checkOutput("rst_mid_crc", crc, last_crc);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("rst_mid_nofin%0d", i), finish, 1'b0);
      checkOutput($sformatf("rst_mid_novalid%0d", i), byte_valid, 1'b0);
    end
    pay = 40'hC0FFEE0042;
    build_expected(pay, P, 1'b1);
    applyStimulus(pay);
    receive_packet(P + 4, 1'b1, -1, -1, '0, cyc);
    check_packet("after_rst");

    $display("[TB] back-to-back with request held high");
    pay   = 40'h1122334455;
    pay_b = 40'hF0E1D2C3B4;
    build_expected(pay_b, P, 1'b1);
    exp_a = expq;
    build_expected(pay, P, 1'b1);
    byte_ready = 1'b1;
    data       = pay;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data = pay_b;
    for (int c = 0; c < 2 * (P + 5); c++) begin
      if (c == P + 5) data_valid = 1'b0;
      if (c < P + 4) begin
        checkOutput($sformatf("b2b_a_valid%0d", c), byte_valid, 1'b1);
        checkOutput($sformatf("b2b_a_byte%0d", c), obyte, expq[c]);
      end else if (c == P + 4) begin
        checkOutput("b2b_a_finish", finish, 1'b1);
        checkOutput("b2b_a_gap", byte_valid, 1'b0);
        checkOutput("b2b_a_crc", crc, exp_crc);
      end else if (c < 2 * P + 9) begin
        checkOutput($sformatf("b2b_b_valid%0d", c), byte_valid, 1'b1);
        checkOutput($sformatf("b2b_b_byte%0d", c), obyte, exp_a[c - (P + 5)]);
      end else begin
        checkOutput("b2b_b_finish", finish, 1'b1);
        checkOutput("b2b_b_gap", byte_valid, 1'b0);
      end
      @(posedge clk); #1;
    end
    build_expected(pay_b, P, 1'b1);
    checkOutput("b2b_b_crc", crc, exp_crc);
    byte_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/crc16_tx_framer.md
Name: crc16_tx_framer

Overview:
- Transmit-side packet framer for the motion-board serial link; counterpart to the CRC16 receive checker.
- Latches a parallel payload word and emits it one byte at a time over a valid/ready handshake, normally into the UART TX.
- Byte sequence: header 0xFF, 0xFA, then the payload (MSB byte first), then the CRC16 (high byte, then low byte).
- The CRC is computed serially as bytes leave the block, so no extra latency is added.

Parameters:
- PAYLOAD_SIZE, 5: payload bytes per packet, legal range 1..32. Default gives a 9-byte packet.
- CRC_INCLUDE_HEADER, 1: 1 = the two header bytes are fed into the CRC; 0 = CRC covers payload only.

Ports:
- iClk  in  1  system clock, 50 MHz.
- iRst  in  1  synchronous reset, active-high.
- iDataValid  in  1  request to send iData. Sampled only when oReady=1.
- iData  in  PAYLOAD_SIZE*8  payload. Byte k (k=0 sent first) is iData[8*(PAYLOAD_SIZE-k)-1 -: 8].
- oReady  out  1  high only in IDLE; framer can accept a new payload.
- oByte  out  8  current output byte.
- oByteValid  out  1  oByte is valid.
- iByteReady  in  1  downstream accepts oByte this cycle.
- oFinish  out  1  one-cycle pulse after the last CRC byte is accepted.
- oCrc  out  16  CRC of the most recent completed packet; held until the next completion.

Behaviour:
- Clock and reset: one clock, synchronous active-high reset.
- Reset values: oReady=1, oByte=0x00, oByteValid=0, oFinish=0, oCrc=0x0000, state=IDLE, CRC accumulator=0x0000.
- Reset mid-packet aborts the packet. No further bytes are emitted and oFinish does not pulse. Reset has priority over all other inputs.
- CRC definition: CRC-16/XMODEM.
  - Polynomial 0x1021, init 0x0000, MSB-first, no reflection, no final XOR.
  - One full byte is folded per accepted byte via an 8-bit unrolled combinational update. No bit-serial multi-cycle loop.
- Transfer rule: a byte transfers on a clock edge where oByteValid=1 and iByteReady=1.
  - While oByteValid=1 and iByteReady=0, oByte must stay stable.
  - oByteValid never drops before its byte transfers.
- States:
  - IDLE: on iDataValid=1, latch iData into the shift register and clear the CRC accumulator. Next cycle the state is HDR0 with oByteValid=1, oByte=0xFF. With iDataValid=0, stay in IDLE.
  - HDR0: on transfer, go to HDR1 with oByte=0xFA. Fold 0xFF into the CRC only if CRC_INCLUDE_HEADER=1.
  - HDR1: on transfer, go to PAYLOAD with oByte = payload byte 0. Fold 0xFA conditionally, as in HDR0.
  - PAYLOAD: on each transfer, fold the byte, shift, and increment the byte counter (width clog2(PAYLOAD_SIZE+1)). After byte PAYLOAD_SIZE-1 transfers, go to CRC_HI with oByte = new CRC[15:8]. The CRC must include the byte transferring in this same cycle (forwarded value).
  - CRC_HI: on transfer, go to CRC_LO with oByte = CRC[7:0].
  - CRC_LO: on transfer, go to IDLE. Set oByteValid=0, oFinish=1 for one cycle, and oCrc = packet CRC.
- iDataValid outside IDLE is ignored and no payload is queued. Upstream must hold iDataValid or retry.
- Throughput: with iByteReady tied high, packet bytes appear on PAYLOAD_SIZE+4 consecutive cycles. The request to the next first byte takes 1 cycle. The minimum packet period is PAYLOAD_SIZE+5 cycles, because IDLE lasts one cycle.
- The same-cycle request rule applies: in the oFinish cycle oReady=1, and iDataValid is accepted in that cycle.
- Changes to iData after the latch do not affect the packet in flight.

Test Plan:
- Known vector: PAYLOAD_SIZE=9, CRC_INCLUDE_HEADER=0, iData="123456789", iByteReady=1.
  - Required bytes: FF FA 31 32 33 34 35 36 37 38 39 31 C3 on 13 consecutive cycles.
  - oFinish pulses one cycle after C3; oCrc=0x31C3.
- Trivial CRC: PAYLOAD_SIZE=1, CRC_INCLUDE_HEADER=0, iData=0x00 -> bytes FF FA 00 00 00, oCrc=0x0000.
- Defaults, iData=0x8080800000, random iByteReady backpressure (about 50% duty):
  - Byte stream is identical to the no-backpressure run.
  - oByte is stable whenever stalled.
  - The trailing CRC equals the value from the bit-accurate software model.
  - A loopback into the receive checker reports success.
- Ignored request: pulse iDataValid with a different payload while in PAYLOAD state -> the current packet is unchanged, and no second packet starts after oFinish.
- Reset mid-packet: assert iRst while the third payload byte is presented.
  - Next cycle: oByteValid=0, oReady=1, no oFinish, oCrc unchanged.
  - A following packet is framed correctly from 0xFF.
- Back-to-back: hold iDataValid=1 with two payloads -> the second 0xFF appears exactly PAYLOAD_SIZE+5 cycles after the first 0xFF.
